// File: rtl/host_display_mode_pipe.sv
// Host display-mode handshake with frame-aligned grayscale apply and a delay-matched video pipeline.
// Define HOST_DISPLAY_MODE_BT601_EN for BT.601 luma weights (needs PIPE_STAGES >= 2).
module host_display_mode_pipe #(
    parameter logic        SUPPORTS_GRAYSCALE = 1'b0,
    parameter int unsigned COLOR_W            = 8,
    parameter int unsigned PIPE_STAGES        = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 notify_valid,
    input  logic                 notify_grayscale,
    output logic                 notify_done,
    output logic                 notify_affirm_grayscale,
    input  logic                 in_vs,
    input  logic                 in_hs,
    input  logic                 in_de,
    input  logic [3*COLOR_W-1:0] in_rgb,
    output logic                 out_vs,
    output logic                 out_hs,
    output logic                 out_de,
    output logic [3*COLOR_W-1:0] out_rgb,
    output logic                 grayscale_active
);
    localparam int unsigned RGB_W = 3 * COLOR_W;
`ifdef HOST_DISPLAY_MODE_BT601_EN
    localparam int unsigned CONV_STAGE = 1;
`else
    localparam int unsigned CONV_STAGE = 0;
`endif

    logic pending_gs;
    logic vs_prev;
    logic done_q;
    logic gs_active_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_gs  <= 1'b0;
            vs_prev     <= 1'b0;
            done_q      <= 1'b0;
            gs_active_q <= 1'b0;
        end else begin
            done_q  <= notify_valid;
            vs_prev <= in_vs;
            if (notify_valid)
                pending_gs <= notify_grayscale & SUPPORTS_GRAYSCALE;
            // Non-blocking read of pending_gs: a request arriving on the vs edge waits a frame.
            if (in_vs && !vs_prev)
                gs_active_q <= pending_gs;
        end
    end

    assign notify_done             = done_q;
    assign notify_affirm_grayscale = pending_gs;
    assign grayscale_active        = gs_active_q;

    logic             vs_pipe  [PIPE_STAGES];
    logic             hs_pipe  [PIPE_STAGES];
    logic             de_pipe  [PIPE_STAGES];
    logic [RGB_W-1:0] rgb_pipe [PIPE_STAGES];
    logic [RGB_W-1:0] stage0_rgb;
    logic [RGB_W-1:0] conv_rgb;

    if (SUPPORTS_GRAYSCALE) begin : g_gs
        logic [COLOR_W-1:0] in_r, in_g, in_b, luma;
        assign {in_r, in_g, in_b} = in_rgb;
`ifdef HOST_DISPLAY_MODE_BT601_EN
        localparam int unsigned PROD_W = COLOR_W + 8;
        if (PIPE_STAGES < 2) begin : g_bad_depth
            $error("HOST_DISPLAY_MODE_BT601_EN requires PIPE_STAGES >= 2");
        end
        logic [PROD_W-1:0] p_r, p_g, p_b, sum;
        logic              mode_s1;
        // Stage 1 holds products and the mode sampled with the pixel; stage 2 sums and selects.
        always_ff @(posedge clk) begin
            if (reset) begin
                p_r     <= '0;
                p_g     <= '0;
                p_b     <= '0;
                mode_s1 <= 1'b0;
            end else begin
                p_r     <= PROD_W'(in_r) * PROD_W'(77);
                p_g     <= PROD_W'(in_g) * PROD_W'(150);
                p_b     <= PROD_W'(in_b) * PROD_W'(29);
                mode_s1 <= gs_active_q;
            end
        end
        assign sum        = p_r + p_g + p_b;
        assign luma       = COLOR_W'(sum >> 8);
        assign conv_rgb   = mode_s1 ? {luma, luma, luma} : rgb_pipe[0];
        assign stage0_rgb = in_rgb;
`else
        logic [COLOR_W+1:0] sum;
        assign sum        = ({2'b00, in_r} << 1) + {2'b00, in_g} + {2'b00, in_b};
        assign luma       = COLOR_W'(sum >> 2);
        assign conv_rgb   = gs_active_q ? {luma, luma, luma} : in_rgb;
        assign stage0_rgb = conv_rgb;
`endif
    end else begin : g_no_gs
`ifdef HOST_DISPLAY_MODE_BT601_EN
        assign conv_rgb = rgb_pipe[0];
`else
        assign conv_rgb = in_rgb;
`endif
        assign stage0_rgb = in_rgb;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
                vs_pipe[i]  <= 1'b0;
                hs_pipe[i]  <= 1'b0;
                de_pipe[i]  <= 1'b0;
                rgb_pipe[i] <= '0;
            end
        end else begin
            vs_pipe[0]  <= in_vs;
            hs_pipe[0]  <= in_hs;
            de_pipe[0]  <= in_de;
            rgb_pipe[0] <= stage0_rgb;
            for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                vs_pipe[i]  <= vs_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                de_pipe[i]  <= de_pipe[i-1];
                rgb_pipe[i] <= (i == CONV_STAGE) ? conv_rgb : rgb_pipe[i-1];
            end
        end
    end

    assign out_vs  = vs_pipe[PIPE_STAGES-1];
    assign out_hs  = hs_pipe[PIPE_STAGES-1];
    assign out_de  = de_pipe[PIPE_STAGES-1];
    assign out_rgb = rgb_pipe[PIPE_STAGES-1];
endmodule

// File: tb/tb_host_display_mode_pipe.sv
// Directed bench for host_display_mode_pipe: four instances differing in support flag and depth.
module tb_host_display_mode_pipe;
`ifdef HOST_DISPLAY_MODE_BT601_EN
    localparam logic [7:0]  GRAY    = 8'd123;
    localparam int unsigned P_SMALL = 2;
`else
    localparam logic [7:0]  GRAY    = 8'd135;
    localparam int unsigned P_SMALL = 1;
`endif
    localparam logic [23:0] COLOR    = {8'd200, 8'd100, 8'd40};
    localparam logic [23:0] GRAY_PIX = {GRAY, GRAY, GRAY};
    localparam logic [23:0] WHITE    = {8'd255, 8'd255, 8'd255};

    logic        clk, reset, notify_valid, notify_grayscale;
    logic        in_vs, in_hs, in_de;
    logic [23:0] in_rgb;

    logic        done_a, aff_a, vs_a, hs_a, de_a, gs_a;
    logic        done_n, aff_n, vs_n, hs_n, de_n, gs_n;
    logic        done_s, aff_s, vs_s, hs_s, de_s, gs_s;
    logic        done_l, aff_l, vs_l, hs_l, de_l, gs_l;
    logic [23:0] rgb_a, rgb_n, rgb_s, rgb_l;

    int total = 0;
    int bad   = 0;

    host_display_mode_pipe #(.SUPPORTS_GRAYSCALE(1'b1), .COLOR_W(8), .PIPE_STAGES(2)) u_a (
        .clk(clk), .reset(reset), .notify_valid(notify_valid), .notify_grayscale(notify_grayscale),
        .notify_done(done_a), .notify_affirm_grayscale(aff_a), .in_vs(in_vs), .in_hs(in_hs),
        .in_de(in_de), .in_rgb(in_rgb), .out_vs(vs_a), .out_hs(hs_a), .out_de(de_a),
        .out_rgb(rgb_a), .grayscale_active(gs_a));

    host_display_mode_pipe #(.SUPPORTS_GRAYSCALE(1'b0), .COLOR_W(8), .PIPE_STAGES(2)) u_n (
        .clk(clk), .reset(reset), .notify_valid(notify_valid), .notify_grayscale(notify_grayscale),
        .notify_done(done_n), .notify_affirm_grayscale(aff_n), .in_vs(in_vs), .in_hs(in_hs),
        .in_de(in_de), .in_rgb(in_rgb), .out_vs(vs_n), .out_hs(hs_n), .out_de(de_n),
        .out_rgb(rgb_n), .grayscale_active(gs_n));

    host_display_mode_pipe #(.SUPPORTS_GRAYSCALE(1'b1), .COLOR_W(8), .PIPE_STAGES(P_SMALL)) u_s (
        .clk(clk), .reset(reset), .notify_valid(notify_valid), .notify_grayscale(notify_grayscale),
        .notify_done(done_s), .notify_affirm_grayscale(aff_s), .in_vs(in_vs), .in_hs(in_hs),
        .in_de(in_de), .in_rgb(in_rgb), .out_vs(vs_s), .out_hs(hs_s), .out_de(de_s),
        .out_rgb(rgb_s), .grayscale_active(gs_s));

    host_display_mode_pipe #(.SUPPORTS_GRAYSCALE(1'b1), .COLOR_W(8), .PIPE_STAGES(4)) u_l (
        .clk(clk), .reset(reset), .notify_valid(notify_valid), .notify_grayscale(notify_grayscale),
        .notify_done(done_l), .notify_affirm_grayscale(aff_l), .in_vs(in_vs), .in_hs(in_hs),
        .in_de(in_de), .in_rgb(in_rgb), .out_vs(vs_l), .out_hs(hs_l), .out_de(de_l),
        .out_rgb(rgb_l), .grayscale_active(gs_l));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // After k edges from a one-cycle vs/hs-high, de-low pulse, only the depth-k instance shows it.
    task automatic check_lat(input int unsigned k);
        check($sformatf("lat%0d_vs_a", k), 32'(vs_a), 32'(k == 2));
        check($sformatf("lat%0d_hs_a", k), 32'(hs_a), 32'(k == 2));
        check($sformatf("lat%0d_de_a", k), 32'(de_a), 32'(k != 2));
        check($sformatf("lat%0d_vs_s", k), 32'(vs_s), 32'(k == P_SMALL));
        check($sformatf("lat%0d_hs_s", k), 32'(hs_s), 32'(k == P_SMALL));
        check($sformatf("lat%0d_de_s", k), 32'(de_s), 32'(k != P_SMALL));
        check($sformatf("lat%0d_vs_l", k), 32'(vs_l), 32'(k == 4));
        check($sformatf("lat%0d_hs_l", k), 32'(hs_l), 32'(k == 4));
        check($sformatf("lat%0d_de_l", k), 32'(de_l), 32'(k != 4));
    endtask

    initial begin
        reset = 1'b1; notify_valid = 1'b0; notify_grayscale = 1'b0;
        in_vs = 1'b0; in_hs = 1'b0; in_de = 1'b0; in_rgb = '0;
        tick(2);
        check("rst_rgb_a", 32'(rgb_a), 32'h0);
        check("rst_done_a", 32'(done_a), 32'h0);
        check("rst_aff_a", 32'(aff_a), 32'h0);
        check("rst_gs_a", 32'(gs_a), 32'h0);
        check("rst_de_l", 32'(de_l), 32'h0);

        reset = 1'b0; in_rgb = COLOR; in_de = 1'b1;
        tick(2);
        check("pass_rgb_a", 32'(rgb_a), 32'(COLOR));
        check("pass_done_a", 32'(done_a), 32'h0);
        check("pass_aff_a", 32'(aff_a), 32'h0);
        tick(2);
        check("pass_rgb_s", 32'(rgb_s), 32'(COLOR));
        check("pass_rgb_l", 32'(rgb_l), 32'(COLOR));
        check("pass_rgb_n", 32'(rgb_n), 32'(COLOR));

        in_vs = 1'b1; in_hs = 1'b1; in_de = 1'b0;
        tick(1);
        in_vs = 1'b0; in_hs = 1'b0; in_de = 1'b1;
        check_lat(1);
        for (int unsigned k = 2; k <= 5; k++) begin
            tick(1);
            check_lat(k);
        end
        check("lat_gs_a", 32'(gs_a), 32'h0);

        // Mid-frame request: ack next cycle, video untouched until the next vs rise.
        notify_valid = 1'b1; notify_grayscale = 1'b1;
        tick(1);
        notify_valid = 1'b0;
        check("req_done_a", 32'(done_a), 32'h1);
        check("req_aff_a", 32'(aff_a), 32'h1);
        check("req_done_n", 32'(done_n), 32'h1);
        check("req_aff_n", 32'(aff_n), 32'h0);
        check("req_gs_a", 32'(gs_a), 32'h0);
        tick(1);
        check("req_done_off_a", 32'(done_a), 32'h0);
        check("req_aff_hold_a", 32'(aff_a), 32'h1);
        tick(3);
        check("req_rgb_a", 32'(rgb_a), 32'(COLOR));
        check("req_rgb_l", 32'(rgb_l), 32'(COLOR));

        in_vs = 1'b1;
        tick(1);
        in_vs = 1'b0;
        check("apply_gs_a", 32'(gs_a), 32'h1);
        check("apply_gs_n", 32'(gs_n), 32'h0);
        tick(1);
        check("apply_edge_rgb_a", 32'(rgb_a), 32'(COLOR));
        check("apply_edge_rgb_s", 32'(rgb_s), 32'((P_SMALL == 1) ? GRAY_PIX : COLOR));
        tick(1);
        check("apply_rgb_a", 32'(rgb_a), 32'(GRAY_PIX));
        tick(2);
        check("apply_rgb_l", 32'(rgb_l), 32'(GRAY_PIX));
        check("apply_rgb_s", 32'(rgb_s), 32'(GRAY_PIX));
        check("apply_rgb_n", 32'(rgb_n), 32'(COLOR));

        // Request on the vs-rise cycle: that edge applies the old pending value.
        notify_valid = 1'b1; notify_grayscale = 1'b0; in_vs = 1'b1;
        tick(1);
        notify_valid = 1'b0; in_vs = 1'b0;
        check("coin_gs_a", 32'(gs_a), 32'h1);
        check("coin_done_a", 32'(done_a), 32'h1);
        check("coin_aff_a", 32'(aff_a), 32'h0);
        tick(2);
        in_vs = 1'b1;
        tick(1);
        in_vs = 1'b0;
        check("coin_next_gs_a", 32'(gs_a), 32'h0);
        tick(4);
        check("coin_rgb_a", 32'(rgb_a), 32'(COLOR));
        check("coin_rgb_l", 32'(rgb_l), 32'(COLOR));

        notify_valid = 1'b1; notify_grayscale = 1'b1;
        tick(1);
        check("b2b1_done_a", 32'(done_a), 32'h1);
        check("b2b1_aff_a", 32'(aff_a), 32'h1);
        notify_grayscale = 1'b0;
        tick(1);
        check("b2b2_done_a", 32'(done_a), 32'h1);
        check("b2b2_aff_a", 32'(aff_a), 32'h0);
        notify_grayscale = 1'b1;
        tick(1);
        check("b2b3_done_a", 32'(done_a), 32'h1);
        check("b2b3_aff_a", 32'(aff_a), 32'h1);
        notify_valid = 1'b0;
        tick(1);
        check("b2b_end_done_a", 32'(done_a), 32'h0);
        check("b2b_end_aff_a", 32'(aff_a), 32'h1);
        check("b2b_end_gs_a", 32'(gs_a), 32'h0);
        in_vs = 1'b1;
        tick(1);
        in_vs = 1'b0;
        check("b2b_gs_a", 32'(gs_a), 32'h1);
        tick(4);
        check("b2b_rgb_a", 32'(rgb_a), 32'(GRAY_PIX));
        check("b2b_rgb_l", 32'(rgb_l), 32'(GRAY_PIX));
        check("b2b_rgb_n", 32'(rgb_n), 32'(COLOR));
        check("b2b_gs_n", 32'(gs_n), 32'h0);

        in_rgb = WHITE;
        tick(4);
        check("white_rgb_a", 32'(rgb_a), 32'(WHITE));
        check("white_rgb_s", 32'(rgb_s), 32'(WHITE));
        check("white_rgb_l", 32'(rgb_l), 32'(WHITE));

        // Reset mid-frame while grayscale is active.
        in_rgb = COLOR; in_hs = 1'b1; reset = 1'b1;
        tick(1);
        check("mrst_rgb_a", 32'(rgb_a), 32'h0);
        check("mrst_de_a", 32'(de_a), 32'h0);
        check("mrst_hs_a", 32'(hs_a), 32'h0);
        check("mrst_gs_a", 32'(gs_a), 32'h0);
        check("mrst_aff_a", 32'(aff_a), 32'h0);
        check("mrst_rgb_l", 32'(rgb_l), 32'h0);
        check("mrst_de_l", 32'(de_l), 32'h0);
        reset = 1'b0; in_hs = 1'b0;
        tick(4);
        check("post_rgb_a", 32'(rgb_a), 32'(COLOR));
        check("post_rgb_l", 32'(rgb_l), 32'(COLOR));
        check("post_gs_a", 32'(gs_a), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/host_display_mode_pipe.md
Name: host_display_mode_pipe

Overview:
- Parametrised, pipelined successor to the host display-mode block.
- Accepts host display-mode notifications (grayscale request) with a registered done handshake.
- Defers the mode change to the next frame boundary so no frame is half-converted.
- Passes video through a configurable-depth pipeline that applies grayscale conversion to a generic-width RGB stream, with all sync signals delay-matched.

Parameters:
- SUPPORTS_GRAYSCALE, 1'b0, when 0 the block never enters grayscale; all requests are affirmed as not supported.
- COLOR_W, 8, bits per colour channel (legal 4..12).
- PIPE_STAGES, 2, video pipeline latency in clk cycles (legal 1..4).

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  synchronous, active-high reset
- notify_valid  in  1  host display-mode notification strobe
- notify_grayscale  in  1  requested grayscale mode, sampled when notify_valid=1
- notify_done  out  1  one-cycle acknowledge
- notify_affirm_grayscale  out  1  1 = grayscale_supported, 0 = grayscale_not_supported
- in_vs, in_hs, in_de  in  1 each  input sync / data enable
- in_rgb  in  3*COLOR_W  {red, green, blue}
- out_vs, out_hs, out_de  out  1 each  delayed sync / data enable
- out_rgb  out  3*COLOR_W  converted or passed-through pixel
- grayscale_active  out  1  mode currently applied to video

Behaviour:
- Clock is clk; reset is synchronous, active-high. All state is sampled on the rising edge of clk.
- Reset values:
  - all out_* = 0; notify_done = 0; notify_affirm_grayscale = 0; grayscale_active = 0.
  - Internal pending_gs = 0; previous-vs register = 0; all pipeline registers cleared.
- Handshake:
  - Cycle N with notify_valid=1: pending_gs <= notify_grayscale & SUPPORTS_GRAYSCALE.
  - Cycle N+1: notify_done = 1 for exactly one cycle.
  - Back-to-back valids give back-to-back done pulses; the last request wins.
  - notify_done is 0 whenever notify_valid was 0 in the previous cycle.
- notify_affirm_grayscale = pending_gs (registered). It updates in the same cycle notify_done rises and is independent of frame timing.
- Frame-boundary apply:
  - Rising edge of in_vs (in_vs=1 and previous in_vs=0) loads grayscale_active <= pending_gs.
  - grayscale_active is not otherwise written.
- Simultaneous events: notify_valid in the same cycle as a vs rising edge → the apply uses the old pending_gs; the new request applies at the following frame.
- Video pipeline:
  - PIPE_STAGES registers on vs, hs, de and rgb; output latency is exactly PIPE_STAGES cycles for every signal.
  - Stage 1 computes the mode decision using grayscale_active as sampled in the cycle the pixel enters.
  - A mode change therefore never splits a pixel's channels across modes.
- Conversion (default): sum = 2R + G + B in COLOR_W+2 bits, no overflow possible; luma = sum[COLOR_W+1:2] (truncate). When grayscale is applied, R = G = B = luma.
- Passthrough when grayscale is not applied: rgb is bit-exact, delayed only.
- rgb is converted regardless of de; blanking pixels pass through the same arithmetic.
- Reset mid-frame: pipeline flushes to zeros; the first output frame after reset is in colour until a vs edge follows an accepted request.
- SUPPORTS_GRAYSCALE=0: conversion logic is not generated; grayscale_active stays 0; affirm stays 0.

Optional Feature:
- HOST_DISPLAY_MODE_BT601_EN defined: luma = (77R + 150G + 29B) >> 8.
  - Products are COLOR_W+8 bits wide, computed over two pipeline stages.
  - PIPE_STAGES must be ≥ 2; elaboration error otherwise.
- Not defined: the 2R+G+B shift-add approximation above.

Test Plan:
- Reset, then in_rgb={200,100,40} with SUPPORTS_GRAYSCALE=1, no request → after PIPE_STAGES cycles out_rgb={200,100,40}; notify_done=0; affirm=0.
- notify_valid=1, notify_grayscale=1 mid-frame → notify_done high for exactly cycle N+1; affirm=1 at N+1; out_rgb stays colour until the next in_vs rise. After that rise, pixel {200,100,40} → {135,135,135}; with BT601_EN → {123,123,123}.
- notify_valid coincident with an in_vs rise → grayscale_active unchanged at that edge and flips at the next vs rise.
- Three consecutive valid cycles with requests 1,0,1 → three done pulses; final affirm=1; the next frame is grayscale.
- SUPPORTS_GRAYSCALE=0, request grayscale → done pulses, affirm=0, output never converted.
- Assert reset mid-frame while grayscale is active → next cycle all outputs are 0 and grayscale_active=0. in_de/hs/vs delay equals PIPE_STAGES for PIPE_STAGES = 1 and 4; check at {255,255,255} → luma 255 with no overflow.
